match_ctrl: RTL
===============

// Module: match_ctrl
// PURPOSE
//  Round/match sequencer sitting directly upstream of the physics engine: gates its
//  per-frame update enable, consumes its game_over/winner/valid outputs, keeps both
//  scores, inserts a freeze pause after every point and declares the match winner.
//  Feeds the physics enable input; scores and state go to render/HUD.
// PARAMETERS
//  WIN_SCORE     4'd15  points needed to win the match (1..15)
//  PAUSE_FRAMES  8'd60  frame_tick count the game stays frozen after a point (0 = no pause)
// PORTS
//  clk           in   1  system clock
//  rst           in   1  asynchronous, active-high reset
//  frame_tick    in   1  one-cycle pulse per video frame
//  start_btn     in   1  level, synchronous to clk; rising edge is the start event
//  phys_game_over in  1  point-ended flag from the physics engine
//  phys_winner   in   2  1 = P1 scored, 2 = P2 scored, 0/3 = none
//  phys_valid    in   1  physics outputs updated this cycle
//  phys_en       out  1  physics update enable, one-cycle pulse
//  p1_score      out  4  P1 points
//  p2_score      out  4  P2 points
//  state         out  2  0 IDLE, 1 PLAY, 2 PAUSE, 3 OVER
//  match_winner  out  2  0 none, 1 P1, 2 P2
//  point_pulse   out  1  one-cycle pulse when a point is credited
// BEHAVIOUR
//  - Reset (async, rst=1): state IDLE, all outputs 0, pause counter 0, start edge reg 0.
//  - start_edge = start_btn & ~start_btn_d (one registered delay).
//  - IDLE: phys_en=0. start_edge -> PLAY, scores and match_winner cleared same edge.
//  - PLAY: phys_en registered: phys_en <= frame_tick when state==PLAY and no point
//    is being credited this cycle; i.e. 1-cycle latency tick -> enable.
//  - Point credit: in PLAY, phys_valid & phys_game_over & winner in {1,2}:
//    winner's score +1 (saturating at 15), point_pulse=1 next cycle.
//    If new score meets win condition -> OVER, match_winner = scorer.
//    Else -> PAUSE, pause counter loaded with PAUSE_FRAMES; if PAUSE_FRAMES==0, -> PLAY.
//  - phys_game_over with winner 0 or 3: ignored (no credit, stay in PLAY).
//  - phys_valid/phys_game_over outside PLAY: ignored.
//  - Credit and frame_tick in same cycle: credit wins, phys_en stays 0.
//  - PAUSE: phys_en=0; each frame_tick decrements counter; tick at counter==1 -> PLAY
//    (exactly PAUSE_FRAMES ticks frozen; first enable on tick PAUSE_FRAMES+1).
//  - OVER: phys_en=0, scores and match_winner held. start_edge -> PLAY, scores cleared.
//  - start_edge in PLAY or PAUSE: ignored.
//  - Win condition (default): score == WIN_SCORE.
//  - Reset mid-match: immediate return to IDLE, scores 0, phys_en drops asynchronously.
// CONFIGURATION
//  DEUCE_RULE_EN defined: win needs score >= WIN_SCORE AND lead >= 2 over opponent;
//    if a score saturates at 15 with lead < 2, the next point by the leader wins
//    (lead of 1 at 15 accepted) so the match always terminates.
//  Not defined: first to WIN_SCORE wins; no lead requirement.
// TESTING
//  1 rst=1 then release -> state=0, scores=0, phys_en=0; frame_ticks give no phys_en.
//  2 start_btn rise, 3 frame_ticks -> state=1, exactly 3 phys_en pulses, each 1 cycle after tick.
//  3 PLAY, valid+game_over+winner=2 -> p2_score=1, point_pulse once, state=2;
//    60 ticks no phys_en, tick 61 produces phys_en, state=1.
//  4 game_over with winner=0, and valid+game_over coincident with frame_tick -> no
//    credit for first; second credits and suppresses that phys_en.
//  5 WIN_SCORE=3, P1 scores 3 -> state=3, match_winner=1; start edge -> scores 0, state=1.
//  6 DEUCE_RULE_EN, WIN_SCORE=3: 3-2 not over; 4-2 -> OVER, match_winner=1.

Source files
------------

// File: rtl/match_ctrl_if.sv
// Bus between the match sequencer and its surroundings (physics engine, HUD).
// The slave side is the sequencer; the master side is whoever drives frame
// timing, the start button and the physics results.
interface match_ctrl_if;
  logic       frame_tick;
  logic       start_btn;
  logic       phys_game_over;
  logic [1:0] phys_winner;
  logic       phys_valid;
  logic       phys_en;
  logic [3:0] p1_score;
  logic [3:0] p2_score;
  logic [1:0] state;
  logic [1:0] match_winner;
  logic       point_pulse;

  modport master (
    output frame_tick, start_btn, phys_game_over, phys_winner, phys_valid,
    input  phys_en, p1_score, p2_score, state, match_winner, point_pulse
  );

  modport slave (
    input  frame_tick, start_btn, phys_game_over, phys_winner, phys_valid,
    output phys_en, p1_score, p2_score, state, match_winner, point_pulse
  );
endinterface

// File: rtl/match_ctrl.sv
// Match sequencer: gates the physics update enable, credits points reported
// by the physics engine, freezes play for PAUSE_FRAMES frames after each point
// and declares the match winner.
// Optional feature macro: DEUCE_RULE_EN (win also requires a two-point lead;
// a player already saturated at 15 wins with any further point).
module match_ctrl #(
  parameter logic [3:0] WIN_SCORE    = 4'd15,
  parameter logic [7:0] PAUSE_FRAMES = 8'd60
) (
  input logic        clk,
  input logic        rst,
  match_ctrl_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PLAY  = 2'd1,
    PAUSE = 2'd2,
    OVER  = 2'd3
  } state_t;

  state_t     cur_state;
  state_t     nxt_state;
  logic       start_d;
  logic       start_edge;
  logic       credit;
  logic       p1_scores;
  logic       win_hit;
  logic [3:0] old_score;
  logic [3:0] opp_score;
  logic [3:0] new_score;
  logic [3:0] p1;
  logic [3:0] p2;
  logic [3:0] p1_nxt;
  logic [3:0] p2_nxt;
  logic [1:0] winner;
  logic [1:0] winner_nxt;
  logic [7:0] pause_cnt;
  logic [7:0] pause_cnt_nxt;
  logic       phys_en_r;
  logic       phys_en_nxt;
  logic       pulse_r;
  logic       pulse_nxt;

  assign start_edge = bus.start_btn & ~start_d;
  assign credit     = (cur_state == PLAY) & bus.phys_valid & bus.phys_game_over &
                      ((bus.phys_winner == 2'd1) | (bus.phys_winner == 2'd2));
  assign p1_scores  = (bus.phys_winner == 2'd1);
  assign old_score  = p1_scores ? p1 : p2;
  assign opp_score  = p1_scores ? p2 : p1;
  assign new_score  = (old_score == 4'd15) ? 4'd15 : old_score + 4'd1;

`ifdef DEUCE_RULE_EN
  // A scorer already stuck at 15 cannot widen the lead, so that point wins outright.
  assign win_hit = (new_score >= WIN_SCORE) &&
                   (((new_score > opp_score) && ((new_score - opp_score) >= 4'd2)) ||
                    (old_score == 4'd15));
`else
  assign win_hit = (new_score == WIN_SCORE);
`endif

  // Remember the previous start button level for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) start_d <= 1'b0;
    else     start_d <= bus.start_btn;
  end

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) cur_state <= IDLE;
    else     cur_state <= nxt_state;
  end

  // Next-state decision: start events, point outcomes and pause expiry.
  always_comb begin
    nxt_state = cur_state;
    case (cur_state)
      IDLE:  if (start_edge) nxt_state = PLAY;
      PLAY: begin
        if (credit) begin
          if (win_hit)                   nxt_state = OVER;
          else if (PAUSE_FRAMES != 8'd0) nxt_state = PAUSE;
        end
      end
      PAUSE: if (bus.frame_tick && (pause_cnt <= 8'd1)) nxt_state = PLAY;
      OVER:  if (start_edge) nxt_state = PLAY;
      default: nxt_state = IDLE;
    endcase
  end

  // Next values of scores, winner, pause counter and the registered pulses.
  always_comb begin
    p1_nxt        = p1;
    p2_nxt        = p2;
    winner_nxt    = winner;
    pause_cnt_nxt = pause_cnt;
    phys_en_nxt   = 1'b0;
    pulse_nxt     = 1'b0;
    case (cur_state)
      IDLE, OVER: begin
        if (start_edge) begin
          p1_nxt     = 4'd0;
          p2_nxt     = 4'd0;
          winner_nxt = 2'd0;
        end
      end
      PLAY: begin
        phys_en_nxt = bus.frame_tick & ~credit;
        if (credit) begin
          pulse_nxt = 1'b1;
          if (p1_scores) p1_nxt = new_score;
          else           p2_nxt = new_score;
          if (win_hit) winner_nxt    = bus.phys_winner;
          else         pause_cnt_nxt = PAUSE_FRAMES;
        end
      end
      PAUSE: begin
        if (bus.frame_tick && (pause_cnt != 8'd0)) pause_cnt_nxt = pause_cnt - 8'd1;
      end
      default: ;
    endcase
  end

  // Datapath and output registers; reset clears everything immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p1        <= 4'd0;
      p2        <= 4'd0;
      winner    <= 2'd0;
      pause_cnt <= 8'd0;
      phys_en_r <= 1'b0;
      pulse_r   <= 1'b0;
    end else begin
      p1        <= p1_nxt;
      p2        <= p2_nxt;
      winner    <= winner_nxt;
      pause_cnt <= pause_cnt_nxt;
      phys_en_r <= phys_en_nxt;
      pulse_r   <= pulse_nxt;
    end
  end

  assign bus.phys_en      = phys_en_r;
  assign bus.p1_score     = p1;
  assign bus.p2_score     = p2;
  assign bus.state        = cur_state;
  assign bus.match_winner = winner;
  assign bus.point_pulse  = pulse_r;

endmodule
